// File: rtl/coherence_ctrl.sv
// Snooping MSI bus controller: arbitrates two L1 dcaches onto one RAM port and snoops the peer.
// Optional macro C2C_FORWARD_EN: forward dirty peer data straight to the requester during the writeback.
module coherence_ctrl #(
  parameter int WORD_W    = 32,
  parameter int SNOOP_LAT = 1
) (
  input  logic                   CLK,
  input  logic                   nRST,
  input  logic [1:0]             dREN,
  input  logic [1:0]             dWEN,
  input  logic [1:0][WORD_W-1:0] daddr,
  input  logic [1:0][WORD_W-1:0] dstore,
  input  logic [1:0]             cctrans,
  input  logic [1:0]             ccwrite,
  output logic [1:0]             dwait,
  output logic [1:0][WORD_W-1:0] dload,
  output logic [1:0]             ccwait,
  output logic [1:0]             ccinv,
  output logic [1:0][WORD_W-1:0] ccsnoopaddr,
  output logic                   ramREN,
  output logic                   ramWEN,
  output logic [WORD_W-1:0]      ramaddr,
  output logic [WORD_W-1:0]      ramstore,
  input  logic [WORD_W-1:0]      ramload,
  input  logic                   ramwait
);

  localparam int CNT_W = (SNOOP_LAT > 1) ? $clog2(SNOOP_LAT) : 1;

  typedef enum logic [2:0] {
    S_IDLE, S_WB0, S_WB1, S_SNP, S_FW0, S_FW1, S_RD0, S_RD1
  } state_t;

  state_t             r_state;
  state_t             w_next;
  logic               r_rr;
  logic               r_req;
  logic               r_upg;
  logic [CNT_W-1:0]   r_cnt;

  logic [1:0]         w_reqv;
  logic               w_sel;
  logic               w_peer;
  logic               w_snp_done;
  logic               w_last;
  logic               w_fw_done;

  assign w_reqv     = dREN | dWEN | cctrans;
  // Single requester wins outright; round-robin pointer breaks a tie.
  assign w_sel      = (&w_reqv) ? r_rr : w_reqv[1];
  assign w_peer     = ~r_req;
  assign w_snp_done = (r_cnt == CNT_W'(SNOOP_LAT - 1));
  assign w_fw_done  = dWEN[w_peer] & ~ramwait;

  // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
  always_ff @(posedge CLK or negedge nRST) begin
    if (!nRST) begin
      r_state <= S_IDLE;
      r_rr    <= 1'b0;
      r_req   <= 1'b0;
      r_upg   <= 1'b0;
      r_cnt   <= '0;
    end else begin
      r_state <= w_next;
      if (r_state == S_IDLE) begin
        r_cnt <= '0;
        if (|w_reqv) begin
          r_req <= w_sel;
          r_upg <= ~dREN[w_sel] & ~dWEN[w_sel];
        end
      end else if (r_state == S_SNP && !w_snp_done) begin
        r_cnt <= r_cnt + CNT_W'(1);
      end
      if (w_last) r_rr <= ~r_req;
    end
  end

  // NOTE: every output and w_next gets a default first, so no path through the case can infer a latch.
  always_comb begin
    w_next      = r_state;
    w_last      = 1'b0;
    dwait       = 2'b11;
    dload       = '0;
    ccwait      = 2'b00;
    ccinv       = 2'b00;
    ccsnoopaddr = '0;
    ramREN      = 1'b0;
    ramWEN      = 1'b0;
    ramaddr     = '0;
    ramstore    = '0;

    unique case (r_state)
      S_IDLE: begin
        if (|w_reqv) begin
          if (dWEN[w_sel]) w_next = S_WB0;
          else             w_next = S_SNP;
        end
      end

      S_WB0, S_WB1: begin
        ramWEN        = 1'b1;
        ramaddr       = daddr[r_req];
        ramstore      = dstore[r_req];
        dwait[r_req]  = ramwait;
        if (!ramwait) begin
          if (r_state == S_WB0) begin
            w_next = S_WB1;
          end else begin
            w_next = S_IDLE;
            w_last = 1'b1;
          end
        end
      end

      S_SNP: begin
        ccwait[w_peer]      = 1'b1;
        ccsnoopaddr[w_peer] = daddr[r_req];
        ccinv[w_peer]       = ccwrite[r_req];
        if (w_snp_done) begin
          if (r_upg) begin
            dwait[r_req] = 1'b0;
            w_next       = S_IDLE;
            w_last       = 1'b1;
          end else if (ccwrite[w_peer]) begin
            w_next = S_FW0;
          end else begin
            w_next = S_RD0;
          end
        end
      end

      S_FW0, S_FW1: begin
        // Peer stays snooped while it flushes its dirty block through the RAM port.
        ccwait[w_peer]      = 1'b1;
        ccsnoopaddr[w_peer] = daddr[r_req];
        ccinv[w_peer]       = ccwrite[r_req];
        ramWEN              = dWEN[w_peer];
        ramaddr             = daddr[w_peer];
        ramstore            = dstore[w_peer];
        if (w_fw_done) begin
          dwait[w_peer] = 1'b0;
`ifdef C2C_FORWARD_EN
          dwait[r_req]  = 1'b0;
          dload[r_req]  = dstore[w_peer];
`endif
          if (r_state == S_FW0) begin
            w_next = S_FW1;
          end else begin
`ifdef C2C_FORWARD_EN
            w_next = S_IDLE;
            w_last = 1'b1;
`else
            w_next = S_RD0;
`endif
          end
        end
      end

      S_RD0, S_RD1: begin
        ramREN       = 1'b1;
        ramaddr      = {daddr[r_req][WORD_W-1:3],
                        (r_state == S_RD1) ? 3'b100 : 3'b000};
        dload[r_req] = ramload;
        dwait[r_req] = ramwait;
        if (!ramwait) begin
          if (r_state == S_RD0) begin
            w_next = S_RD1;
          end else begin
            w_next = S_IDLE;
            w_last = 1'b1;
          end
        end
      end

      default: w_next = S_IDLE;
    endcase
  end

endmodule

// File: tb/tb_coherence_ctrl.sv
// Directed self-checking bench for coherence_ctrl (SNOOP_LAT=1); follows C2C_FORWARD_EN if defined.
module tb_coherence_ctrl;

  localparam int W = 32;

  logic              CLK = 1'b0;
  logic              nRST;
  logic [1:0]        dREN, dWEN, cctrans, ccwrite;
  logic [1:0][W-1:0] daddr, dstore;
  logic [1:0]        dwait, ccwait, ccinv;
  logic [1:0][W-1:0] dload, ccsnoopaddr;
  logic              ramREN, ramWEN, ramwait;
  logic [W-1:0]      ramaddr, ramstore, ramload;

  int n_checks = 0;
  int n_errors = 0;

  coherence_ctrl #(.WORD_W(W), .SNOOP_LAT(1)) dut (
    .CLK(CLK), .nRST(nRST),
    .dREN(dREN), .dWEN(dWEN), .daddr(daddr), .dstore(dstore),
    .cctrans(cctrans), .ccwrite(ccwrite),
    .dwait(dwait), .dload(dload), .ccwait(ccwait), .ccinv(ccinv),
    .ccsnoopaddr(ccsnoopaddr),
    .ramREN(ramREN), .ramWEN(ramWEN), .ramaddr(ramaddr), .ramstore(ramstore),
    .ramload(ramload), .ramwait(ramwait)
  );

  always #5 CLK = ~CLK;

  task automatic check(input string tag, input logic [W-1:0] got, input logic [W-1:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s got=0x%0h exp=0x%0h", tag, got, exp);
    end
  endtask

  task automatic cyc();
    @(posedge CLK);
    #1;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog expired");
    $fatal(1, "watchdog");
  end

  initial begin
    nRST = 1'b0; dREN = '0; dWEN = '0; cctrans = '0; ccwrite = '0;
    daddr = '0; dstore = '0; ramload = '0; ramwait = 1'b0;
    repeat (2) @(posedge CLK);
    #1;

    // Reset state
    check("rst_dwait", dwait, 2'b11);
    check("rst_ccwait", ccwait, 2'b00);
    check("rst_ccinv", ccinv, 2'b00);
    check("rst_ramREN", ramREN, 1'b0);
    check("rst_ramWEN", ramWEN, 1'b0);
    check("rst_snoopaddr0", ccsnoopaddr[0], '0);
    check("rst_snoopaddr1", ccsnoopaddr[1], '0);
    check("rst_ramaddr", ramaddr, '0);
    nRST = 1'b1;

    // Clean miss by cache0
    dREN = 2'b01; cctrans = 2'b01; daddr[0] = 32'h100; ramload = 32'hA;
    #1;
    check("cm_idle_dwait", dwait, 2'b11);
    cyc();
    check("cm_snp_ccwait", ccwait, 2'b10);
    check("cm_snp_addr", ccsnoopaddr[1], 32'h100);
    check("cm_snp_ccinv", ccinv, 2'b00);
    check("cm_snp_ramREN", ramREN, 1'b0);
    cyc();
    check("cm_rd0_ramREN", ramREN, 1'b1);
    check("cm_rd0_addr", ramaddr, 32'h100);
    check("cm_rd0_dload", dload[0], 32'hA);
    check("cm_rd0_dwait", dwait, 2'b10);
    check("cm_rd0_ccwait", ccwait, 2'b00);
    cyc();
    ramload = 32'hB; dREN = '0; cctrans = '0;
    #1;
    check("cm_rd1_addr", ramaddr, 32'h104);
    check("cm_rd1_dload", dload[0], 32'hB);
    check("cm_rd1_dwait", dwait, 2'b10);
    cyc();
    check("cm_end_dwait", dwait, 2'b11);
    check("cm_end_ramREN", ramREN, 1'b0);

    // Dirty snoop: cache1 misses, cache0 holds the block in M
    dREN = 2'b10; cctrans = 2'b10; ccwrite = 2'b10; daddr[1] = 32'h200;
    #1;
    cyc();
    ccwrite[0] = 1'b1;
    #1;
    check("ds_snp_ccwait", ccwait, 2'b01);
    check("ds_snp_ccinv", ccinv, 2'b01);
    check("ds_snp_addr", ccsnoopaddr[0], 32'h200);
    cyc();
    dWEN = 2'b01; daddr[0] = 32'h200; dstore[0] = 32'hC;
    #1;
    check("ds_fw0_ramWEN", ramWEN, 1'b1);
    check("ds_fw0_addr", ramaddr, 32'h200);
    check("ds_fw0_store", ramstore, 32'hC);
    check("ds_fw0_ccwait", ccwait, 2'b01);
`ifdef C2C_FORWARD_EN
    check("ds_fw0_dwait", dwait, 2'b00);
    check("ds_fw0_dload", dload[1], 32'hC);
`else
    check("ds_fw0_dwait", dwait, 2'b10);
`endif
    cyc();
    daddr[0] = 32'h204; dstore[0] = 32'hD;
`ifdef C2C_FORWARD_EN
    dREN = '0; cctrans = '0; ccwrite[1] = 1'b0;
`endif
    #1;
    check("ds_fw1_addr", ramaddr, 32'h204);
    check("ds_fw1_store", ramstore, 32'hD);
`ifdef C2C_FORWARD_EN
    check("ds_fw1_dwait", dwait, 2'b00);
    check("ds_fw1_dload", dload[1], 32'hD);
`else
    check("ds_fw1_dwait", dwait, 2'b10);
`endif
    cyc();
    dWEN = '0; ccwrite[0] = 1'b0;
`ifdef C2C_FORWARD_EN
    #1;
    check("ds_end_dwait", dwait, 2'b11);
    check("ds_end_ccwait", ccwait, 2'b00);
`else
    ramload = 32'h11;
    #1;
    check("ds_rd0_ramREN", ramREN, 1'b1);
    check("ds_rd0_addr", ramaddr, 32'h200);
    check("ds_rd0_dload", dload[1], 32'h11);
    check("ds_rd0_dwait", dwait, 2'b01);
    cyc();
    ramload = 32'h22; dREN = '0; cctrans = '0; ccwrite = '0;
    #1;
    check("ds_rd1_addr", ramaddr, 32'h204);
    check("ds_rd1_dload", dload[1], 32'h22);
    cyc();
    check("ds_end_dwait", dwait, 2'b11);
`endif

    // Upgrade S->M by cache0
    cctrans = 2'b01; ccwrite = 2'b01; daddr[0] = 32'h300;
    #1;
    check("up_idle_dwait", dwait, 2'b11);
    cyc();
    check("up_ccinv", ccinv, 2'b10);
    check("up_ccwait", ccwait, 2'b10);
    check("up_addr", ccsnoopaddr[1], 32'h300);
    check("up_ramREN", ramREN, 1'b0);
    check("up_ramWEN", ramWEN, 1'b0);
    check("up_dwait", dwait, 2'b10);
    cctrans = '0; ccwrite = '0;
    cyc();
    check("up_end_dwait", dwait, 2'b11);
    check("up_end_ccinv", ccinv, 2'b00);

    // Reset in the middle of a writeback
    dWEN = 2'b01; daddr[0] = 32'h700; dstore[0] = 32'h77; ramwait = 1'b1;
    #1;
    cyc();
    check("mr_wb_ramWEN", ramWEN, 1'b1);
    nRST = 1'b0; dWEN = '0; ramwait = 1'b0;
    #1;
    check("mr_ramWEN", ramWEN, 1'b0);
    check("mr_dwait", dwait, 2'b11);
    check("mr_ramaddr", ramaddr, '0);
    cyc();
    nRST = 1'b1;

    // Contention with rr=0
    dREN = 2'b11; cctrans = 2'b11; daddr[0] = 32'h400; daddr[1] = 32'h500;
    #1;
    cyc();
    check("ct_a_ccwait", ccwait, 2'b10);
    check("ct_a_addr", ccsnoopaddr[1], 32'h400);
    cyc();
    ramload = 32'h40;
    #1;
    check("ct_a_rd0_addr", ramaddr, 32'h400);
    check("ct_a_rd0_dwait", dwait, 2'b10);
    check("ct_a_rd0_dload", dload[0], 32'h40);
    check("ct_a_snoopaddr_off", ccsnoopaddr[1], '0);
    cyc();
    dREN = 2'b10; cctrans = 2'b10;
    #1;
    check("ct_a_rd1_addr", ramaddr, 32'h404);
    cyc();
    check("ct_idle_dwait", dwait, 2'b11);
    cyc();
    check("ct_b_ccwait", ccwait, 2'b01);
    check("ct_b_addr", ccsnoopaddr[0], 32'h500);
    cyc();
    check("ct_b_rd0_addr", ramaddr, 32'h500);
    check("ct_b_rd0_dwait", dwait, 2'b01);
    cyc();
    dREN = 2'b11; cctrans = 2'b11;
    #1;
    check("ct_b_rd1_addr", ramaddr, 32'h504);
    cyc();
    cyc();
    check("ct_c_ccwait", ccwait, 2'b10);
    check("ct_c_addr", ccsnoopaddr[1], 32'h400);
    dREN = '0; cctrans = '0;
    cyc();
    check("ct_c_rd0_addr", ramaddr, 32'h400);
    cyc();
    cyc();
    check("ct_c_end_dwait", dwait, 2'b11);

    // Writeback stalled by ramwait
    dWEN = 2'b10; daddr[1] = 32'h600; dstore[1] = 32'h66; ramwait = 1'b1;
    #1;
    cyc();
    for (int i = 0; i < 3; i++) begin
      check("wb_stall_dwait", dwait, 2'b11);
      check("wb_stall_ramWEN", ramWEN, 1'b1);
      check("wb_stall_addr", ramaddr, 32'h600);
      check("wb_stall_store", ramstore, 32'h66);
      if (i < 2) cyc();
    end
    ramwait = 1'b0;
    #1;
    check("wb0_done_dwait", dwait, 2'b01);
    cyc();
    daddr[1] = 32'h604; dstore[1] = 32'h67;
    #1;
    check("wb1_ramWEN", ramWEN, 1'b1);
    check("wb1_addr", ramaddr, 32'h604);
    check("wb1_store", ramstore, 32'h67);
    check("wb1_dwait", dwait, 2'b01);
    cyc();
    dWEN = '0;
    #1;
    check("wb_end_ramWEN", ramWEN, 1'b0);
    check("wb_end_dwait", dwait, 2'b11);

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule
